llc_req_arbiter: RTL and testbench
==================================

# llc_req_arbiter

Request arbiter and sequencer in front of the last-level cache (LLC) model. It accepts commands from three requesters (L1 data, L1 instruction, bus snoop), grants one at a time and issues it to the LLC with a valid/ack handshake. It waits for completion and keeps read, write, hit and miss statistics. It sits between the trace/stimulus front end and the LLC.

## Interface
- CMDSIZE, 4, command code width
- ADDR_BITS, 32, address width
- CNT_W, 32, statistics counter width
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before abort (≥1)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- d_valid / d_ready  in / out  1  L1 data requester handshake
- d_cmd, d_addr  in  CMDSIZE, ADDR_BITS  L1 data command and address
- i_valid / i_ready, i_cmd, i_addr  same widths  L1 instruction requester
- s_valid / s_ready, s_cmd, s_addr  same widths  snoop requester
- llc_valid  out  1  one-cycle issue strobe to LLC
- llc_cmd, llc_addr  out  CMDSIZE, ADDR_BITS  issued command and address, held stable ISSUE..WAIT exit
- llc_ack  in  1  LLC completion
- llc_hit  in  1  hit/miss result, sampled with llc_ack
- busy  out  1  high in ISSUE or WAIT
- cmd_err  out  1  one-cycle pulse on a dropped illegal command
- timeout_err  out  1  sticky abort flag
- reads, writes, hits, misses  out  CNT_W  statistics

## Operation
- Command codes:
  - 0: data read
  - 1: data write
  - 2: instruction fetch
  - 3–6: snoop read / write / RWIM / invalidate
  - 8: clear
  - 9: print
  - 7 and 10–15: illegal
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: arbitrate. Snoop has fixed top priority. d and i alternate round-robin; the pointer flips after each d or i grant and resets to d. ready is asserted combinationally only to the winner, and only in IDLE.
- Accept on valid&&ready. Latch cmd and addr.
  - Illegal cmd: pulse cmd_err next cycle, stay IDLE, forward nothing.
  - Legal cmd: go to ISSUE.
- ISSUE: llc_valid=1 for exactly one cycle, then WAIT.
- WAIT: hold until llc_ack, then IDLE. A timeout counter starts at 0 on entry and increments every cycle without ack. When it reaches TIMEOUT_CYCLES: set timeout_err and go to IDLE.
- Statistics, updated in the cycle llc_ack is seen:
  - reads increments for cmd 0 or 2.
  - writes increments for cmd 1.
  - hits or misses increments (by llc_hit) for cmd 0, 1 or 2 only.
  - Snoops and cmd 9 change no counters.
  - cmd 8 ack clears all four counters and timeout_err.
  - All counters saturate at all-ones.

## Timing
- Reset values: every output 0, FSM=IDLE, round-robin pointer=d, counters 0. The asynchronous reset clears llc_valid and busy immediately, including mid-transaction. The in-flight command is discarded and not counted.
- Accept at cycle T gives llc_valid at T+1. Earliest llc_ack is T+2. An ack in ISSUE is ignored.
- ack at A gives IDLE at A+1, where a new accept is possible. Minimum spacing between accepts is 3 cycles.
- ack and timeout in the same cycle: ack wins, the command is counted and timeout_err is not set.
- Simultaneous d, i and s valid: s is granted first, then d and i alternate.
- A requester holds valid, cmd and addr until ready. Deasserting valid early is a protocol violation and needs no handling.

## Configuration
- LLC_ARB_STATS_EN defined: the four counters are implemented as above.
- Not defined: no counter registers exist. reads, writes, hits and misses are tied to 0. cmd 8 still clears timeout_err. All other behaviour is unchanged.

## Structure
- Package llc_pkg holds:
  - CMDSIZE and ADDR_BITS defaults
  - named command-code localparams (CMD_RD_D … CMD_PRINT)
  - the state enum {IDLE, ISSUE, WAIT}
  - function is_legal_cmd
- Sub-module llc_rr_arbiter holds the fixed-priority plus round-robin grant logic and the pointer register. It takes the FSM-IDLE qualifier as an input.
- The top level holds the FSM, command latch, timeout counter and statistics.

## Test plan
- d_valid with cmd 0, addr 0x1000. LLC acks with hit=1 three cycles after llc_valid. Expect: llc_valid exactly one cycle at T+1 with cmd 0 / addr 0x1000; reads=1, hits=1; busy falls the cycle after ack.
- d, i and s all valid at once (cmds 1, 2, 4), immediate acks with hit=0. Expect grant order s, d, i. Expect writes=1, reads=1, misses=2; the snoop leaves all counters unchanged.
- s_valid with cmd 7. Expect cmd_err pulse, no llc_valid, FSM stays IDLE.
- cmd 0 issued and never acked, TIMEOUT_CYCLES=4. Expect timeout_err set after 4 WAIT cycles and FSM back in IDLE. A following cmd 8 with ack clears timeout_err and all counters.
- rst_n pulled low in WAIT. Expect llc_valid and busy 0 immediately and counters 0. After release, the next request is served from IDLE with the pointer at d.
- Build without LLC_ARB_STATS_EN and run 10 mixed reads and writes. Expect reads, writes, hits and misses to stay 0 and all handshakes to be unchanged.

Source files
------------

// File: rtl/llc_pkg.sv
// Shared command codes, FSM state type and command legality check for the
// LLC request arbiter.
package llc_pkg;

  localparam int CMDSIZE_DEF   = 4;
  localparam int ADDR_BITS_DEF = 32;

  localparam logic [31:0] CMD_RD_D     = 32'd0;
  localparam logic [31:0] CMD_WR_D     = 32'd1;
  localparam logic [31:0] CMD_RD_I     = 32'd2;
  localparam logic [31:0] CMD_SNP_RD   = 32'd3;
  localparam logic [31:0] CMD_SNP_WR   = 32'd4;
  localparam logic [31:0] CMD_SNP_RWIM = 32'd5;
  localparam logic [31:0] CMD_SNP_INV  = 32'd6;
  localparam logic [31:0] CMD_CLEAR    = 32'd8;
  localparam logic [31:0] CMD_PRINT    = 32'd9;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} llc_state_e;

  // Codes 7 and 10..15 (and anything wider) are dropped by the arbiter.
  function automatic logic is_legal_cmd(input logic [31:0] cmd);
    return (cmd <= CMD_SNP_INV) || (cmd == CMD_CLEAR) || (cmd == CMD_PRINT);
  endfunction

endpackage

// File: rtl/llc_rr_arbiter.sv
// Grant logic for the LLC arbiter: snoop has fixed top priority, data and
// instruction requesters alternate through a one-bit round-robin pointer.
module llc_rr_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic d_valid,
  input  logic i_valid,
  input  logic s_valid,
  output logic d_grant,
  output logic i_grant,
  output logic s_grant
);

  logic ptr_i;

  always_comb begin
    d_grant = 1'b0;
    i_grant = 1'b0;
    s_grant = 1'b0;
    if (idle) begin
      if (s_valid)
        s_grant = 1'b1;
      else if (d_valid && (!i_valid || !ptr_i))
        d_grant = 1'b1;
      else if (i_valid)
        i_grant = 1'b1;
    end
  end

  // Pointer names the requester favoured at the next d/i conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_i <= 1'b0;
    else if (d_grant)
      ptr_i <= 1'b1;
    else if (i_grant)
      ptr_i <= 1'b0;
  end

endmodule

// File: rtl/llc_req_arbiter.sv
// Request arbiter and sequencer in front of the LLC model. Statistics
// counters exist only when LLC_ARB_STATS_EN is defined.
module llc_req_arbiter
  import llc_pkg::*;
#(
  parameter int CMDSIZE        = CMDSIZE_DEF,
  parameter int ADDR_BITS      = ADDR_BITS_DEF,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 d_valid,
  output logic                 d_ready,
  input  logic [CMDSIZE-1:0]   d_cmd,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [CMDSIZE-1:0]   i_cmd,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [CMDSIZE-1:0]   s_cmd,
  input  logic [ADDR_BITS-1:0] s_addr,
  output logic                 llc_valid,
  output logic [CMDSIZE-1:0]   llc_cmd,
  output logic [ADDR_BITS-1:0] llc_addr,
  input  logic                 llc_ack,
  input  logic                 llc_hit,
  output logic                 busy,
  output logic                 cmd_err,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     reads,
  output logic [CNT_W-1:0]     writes,
  output logic [CNT_W-1:0]     hits,
  output logic [CNT_W-1:0]     misses
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  llc_state_e             state, state_nxt;
  logic                   accept, sel_legal, ack_done, time_out;
  logic [CMDSIZE-1:0]     sel_cmd, lat_cmd;
  logic [ADDR_BITS-1:0]   sel_addr, lat_addr;
  logic [TW-1:0]          tcnt;
  logic                   is_clear;

  llc_rr_arbiter u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .idle    (state == IDLE),
    .d_valid (d_valid),
    .i_valid (i_valid),
    .s_valid (s_valid),
    .d_grant (d_ready),
    .i_grant (i_ready),
    .s_grant (s_ready)
  );

  assign accept = d_ready | i_ready | s_ready;

  always_comb begin
    sel_cmd  = d_cmd;
    sel_addr = d_addr;
    if (s_ready) begin
      sel_cmd  = s_cmd;
      sel_addr = s_addr;
    end else if (i_ready) begin
      sel_cmd  = i_cmd;
      sel_addr = i_addr;
    end
  end

  assign sel_legal = is_legal_cmd(32'(sel_cmd));
  assign is_clear  = (32'(lat_cmd) == CMD_CLEAR);

  // An ack on the final WAIT cycle takes precedence over the timeout.
  always_comb begin
    state_nxt = state;
    ack_done  = 1'b0;
    time_out  = 1'b0;
    case (state)
      IDLE:  if (accept && sel_legal) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (llc_ack) begin
          state_nxt = IDLE;
          ack_done  = 1'b1;
        end else if (tcnt == TCNT_LAST) begin
          state_nxt = IDLE;
          time_out  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_cmd     <= '0;
      lat_addr    <= '0;
      cmd_err     <= 1'b0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cmd_err <= accept && !sel_legal;
      if (accept && sel_legal) begin
        lat_cmd  <= sel_cmd;
        lat_addr <= sel_addr;
      end
      if (state != WAIT)
        tcnt <= '0;
      else
        tcnt <= tcnt + TW'(1);
      if (time_out)
        timeout_err <= 1'b1;
      else if (ack_done && is_clear)
        timeout_err <= 1'b0;
    end
  end

  assign llc_valid = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign llc_cmd   = lat_cmd;
  assign llc_addr  = lat_addr;

`ifdef LLC_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] rd_q, wr_q, hit_q, miss_q;
  logic             is_rd, is_wr, is_cache;

  assign is_rd    = (32'(lat_cmd) == CMD_RD_D) || (32'(lat_cmd) == CMD_RD_I);
  assign is_wr    = (32'(lat_cmd) == CMD_WR_D);
  assign is_cache = is_rd || is_wr;

  // Counters saturate rather than wrap; a clear command zeroes all four.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      hit_q  <= '0;
      miss_q <= '0;
    end else if (ack_done) begin
      if (is_clear) begin
        rd_q   <= '0;
        wr_q   <= '0;
        hit_q  <= '0;
        miss_q <= '0;
      end else begin
        if (is_rd && rd_q != CNT_MAX)
          rd_q <= rd_q + CNT_W'(1);
        if (is_wr && wr_q != CNT_MAX)
          wr_q <= wr_q + CNT_W'(1);
        if (is_cache && llc_hit && hit_q != CNT_MAX)
          hit_q <= hit_q + CNT_W'(1);
        if (is_cache && !llc_hit && miss_q != CNT_MAX)
          miss_q <= miss_q + CNT_W'(1);
      end
    end
  end

  assign reads  = rd_q;
  assign writes = wr_q;
  assign hits   = hit_q;
  assign misses = miss_q;
`else
  logic stats_unused;
  assign stats_unused = llc_hit;
  assign reads  = '0;
  assign writes = '0;
  assign hits   = '0;
  assign misses = '0;
`endif

endmodule

// File: tb/tb_llc_req_arbiter.sv
// Directed, table-driven bench for llc_req_arbiter; expected statistics
// follow LLC_ARB_STATS_EN (zero when the macro is undefined).
module tb_llc_req_arbiter;

  localparam int CW = 4;
  localparam int AW = 32;
  localparam int NW = 3;
  localparam int TO = 4;
  localparam int SAT = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          d_valid = 0, i_valid = 0, s_valid = 0;
  logic          d_ready, i_ready, s_ready;
  logic [CW-1:0] d_cmd = '0, i_cmd = '0, s_cmd = '0;
  logic [AW-1:0] d_addr = '0, i_addr = '0, s_addr = '0;
  logic          llc_valid, llc_ack = 1'b0, llc_hit = 1'b0;
  logic [CW-1:0] llc_cmd;
  logic [AW-1:0] llc_addr;
  logic          busy, cmd_err, timeout_err;
  logic [NW-1:0] reads, writes, hits, misses;

  int checks = 0;
  int errors = 0;
  int m_rd = 0, m_wr = 0, m_hit = 0, m_miss = 0;
  logic m_to = 1'b0;

  llc_req_arbiter #(
    .CMDSIZE(CW), .ADDR_BITS(AW), .CNT_W(NW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .d_valid(d_valid), .d_ready(d_ready), .d_cmd(d_cmd), .d_addr(d_addr),
    .i_valid(i_valid), .i_ready(i_ready), .i_cmd(i_cmd), .i_addr(i_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_cmd(s_cmd), .s_addr(s_addr),
    .llc_valid(llc_valid), .llc_cmd(llc_cmd), .llc_addr(llc_addr),
    .llc_ack(llc_ack), .llc_hit(llc_hit),
    .busy(busy), .cmd_err(cmd_err), .timeout_err(timeout_err),
    .reads(reads), .writes(writes), .hits(hits), .misses(misses)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    int          src;
    logic [3:0]  cmd;
    logic [31:0] addr;
    int          delay;
    logic        hit;
    logic        issue;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int src, input logic v,
                               input logic [3:0] cmd, input logic [31:0] addr);
    case (src)
      0: begin d_valid = v; d_cmd = cmd; d_addr = addr; end
      1: begin i_valid = v; i_cmd = cmd; i_addr = addr; end
      default: begin s_valid = v; s_cmd = cmd; s_addr = addr; end
    endcase
  endtask

  function automatic logic [31:0] expCnt(input int v);
`ifdef LLC_ARB_STATS_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  function automatic int sat(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic modelAck(input logic [3:0] cmd, input logic hit);
    if (cmd == 4'd8) begin
      m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0; m_to = 1'b0;
    end else if (cmd <= 4'd2) begin
      if (cmd == 4'd1) m_wr = sat(m_wr);
      else             m_rd = sat(m_rd);
      if (hit) m_hit  = sat(m_hit);
      else     m_miss = sat(m_miss);
    end
  endtask

  task automatic checkStats(input string tag);
    checkOutput({tag, ".reads"},  32'(reads),  expCnt(m_rd));
    checkOutput({tag, ".writes"}, 32'(writes), expCnt(m_wr));
    checkOutput({tag, ".hits"},   32'(hits),   expCnt(m_hit));
    checkOutput({tag, ".misses"}, 32'(misses), expCnt(m_miss));
    checkOutput({tag, ".timeout_err"}, 32'(timeout_err), 32'(m_to));
  endtask

  // One request from a single requester, acked 'delay' cycles after llc_valid.
  task automatic doTxn(input string tag, input vec_t v);
    applyStimulus(v.src, 1'b1, v.cmd, v.addr);
    #1;
    checkOutput({tag, ".ready"}, 32'({s_ready, i_ready, d_ready}),
                32'(3'b001 << v.src));
    step();
    applyStimulus(v.src, 1'b0, 4'd0, 32'd0);
    if (!v.issue) begin
      checkOutput({tag, ".cmd_err"}, 32'(cmd_err), 32'd1);
      checkOutput({tag, ".llc_valid"}, 32'(llc_valid), 32'd0);
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
      step();
      checkOutput({tag, ".cmd_err_clr"}, 32'(cmd_err), 32'd0);
    end else begin
      checkOutput({tag, ".llc_valid"}, 32'(llc_valid), 32'd1);
      checkOutput({tag, ".llc_cmd"}, 32'(llc_cmd), 32'(v.cmd));
      checkOutput({tag, ".llc_addr"}, llc_addr, v.addr);
      checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
      repeat (v.delay) step();
      checkOutput({tag, ".llc_valid_wait"}, 32'(llc_valid), 32'd0);
      checkOutput({tag, ".llc_cmd_hold"}, 32'(llc_cmd), 32'(v.cmd));
      checkOutput({tag, ".busy_wait"}, 32'(busy), 32'd1);
      llc_ack = 1'b1;
      llc_hit = v.hit;
      step();
      llc_ack = 1'b0;
      llc_hit = 1'b0;
      modelAck(v.cmd, v.hit);
      checkOutput({tag, ".busy_done"}, 32'(busy), 32'd0);
      checkStats(tag);
    end
  endtask

  vec_t tbl[16];
  int   order[3];
  logic [3:0]  ocmd[3];
  logic [31:0] oaddr[3];
  vec_t v;

  initial begin
    tbl[0]  = '{0, 4'd0,  32'h1000, 3, 1'b1, 1'b1};
    tbl[1]  = '{1, 4'd2,  32'h2000, 1, 1'b0, 1'b1};
    tbl[2]  = '{0, 4'd1,  32'h3000, 2, 1'b1, 1'b1};
    tbl[3]  = '{2, 4'd3,  32'h4000, 1, 1'b1, 1'b1};
    tbl[4]  = '{2, 4'd7,  32'h4100, 0, 1'b0, 1'b0};
    tbl[5]  = '{0, 4'd10, 32'h5000, 0, 1'b0, 1'b0};
    tbl[6]  = '{1, 4'd15, 32'h5100, 0, 1'b0, 1'b0};
    tbl[7]  = '{0, 4'd9,  32'h6000, 1, 1'b1, 1'b1};
    tbl[8]  = '{2, 4'd6,  32'h6100, 2, 1'b0, 1'b1};
    tbl[9]  = '{0, 4'd0,  32'h7000, 4, 1'b0, 1'b1};
    tbl[10] = '{1, 4'd2,  32'h7100, 1, 1'b1, 1'b1};
    tbl[11] = '{0, 4'd0,  32'h7200, 1, 1'b1, 1'b1};
    tbl[12] = '{1, 4'd2,  32'h7300, 1, 1'b0, 1'b1};
    tbl[13] = '{0, 4'd1,  32'h7400, 1, 1'b0, 1'b1};
    tbl[14] = '{0, 4'd0,  32'h7500, 1, 1'b1, 1'b1};
    tbl[15] = '{1, 4'd2,  32'h7600, 1, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.llc_valid", 32'(llc_valid), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.cmd_err", 32'(cmd_err), 32'd0);
    checkOutput("rst.llc_cmd", 32'(llc_cmd), 32'd0);
    checkOutput("rst.llc_addr", llc_addr, 32'd0);
    checkStats("rst");
    rst_n = 1'b1;
    step();

    // All three requesters at once: s first, then d, then i
    order[0] = 2; order[1] = 0; order[2] = 1;
    ocmd[0] = 4'd4; ocmd[1] = 4'd1; ocmd[2] = 4'd2;
    oaddr[0] = 32'hA000; oaddr[1] = 32'hA100; oaddr[2] = 32'hA200;
    for (int k = 0; k < 3; k++) applyStimulus(order[k], 1'b1, ocmd[k], oaddr[k]);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("all3.ready%0d", k), 32'({s_ready, i_ready, d_ready}),
                  32'(3'b001 << order[k]));
      step();
      applyStimulus(order[k], 1'b0, 4'd0, 32'd0);
      checkOutput($sformatf("all3.cmd%0d", k), 32'(llc_cmd), 32'(ocmd[k]));
      checkOutput($sformatf("all3.addr%0d", k), llc_addr, oaddr[k]);
      checkOutput($sformatf("all3.noready%0d", k), 32'({s_ready, i_ready, d_ready}), 32'd0);
      step();
      llc_ack = 1'b1;
      step();
      llc_ack = 1'b0;
      modelAck(ocmd[k], 1'b0);
    end
    checkStats("all3");

    for (int n = 0; n < 16; n++) doTxn($sformatf("vec%0d", n), tbl[n]);

    // Ack during ISSUE must be ignored
    applyStimulus(0, 1'b1, 4'd1, 32'h8000);
    step();
    applyStimulus(0, 1'b0, 4'd0, 32'd0);
    llc_ack = 1'b1;
    llc_hit = 1'b1;
    step();
    llc_ack = 1'b0;
    checkOutput("ackissue.busy", 32'(busy), 32'd1);
    checkStats("ackissue.pre");
    step();
    llc_ack = 1'b1;
    step();
    llc_ack = 1'b0;
    llc_hit = 1'b0;
    modelAck(4'd1, 1'b1);
    checkOutput("ackissue.busy_done", 32'(busy), 32'd0);
    checkStats("ackissue");

    // Never acked: abort after TO WAIT cycles, read not counted
    applyStimulus(0, 1'b1, 4'd0, 32'h9000);
    step();
    applyStimulus(0, 1'b0, 4'd0, 32'd0);
    repeat (TO) step();
    checkOutput("to.busy_last", 32'(busy), 32'd1);
    checkOutput("to.err_pre", 32'(timeout_err), 32'd0);
    step();
    m_to = 1'b1;
    checkOutput("to.busy", 32'(busy), 32'd0);
    checkStats("to");
    v = '{0, 4'd8, 32'h9100, 1, 1'b0, 1'b1};
    doTxn("clear", v);

    // Reset in WAIT, then pointer must be back at d
    doTxn("pre_rst", tbl[0]);
    applyStimulus(0, 1'b1, 4'd0, 32'hB000);
    step();
    applyStimulus(0, 1'b0, 4'd0, 32'd0);
    step();
    checkOutput("midrst.busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0; m_to = 1'b0;
    checkOutput("midrst.llc_valid", 32'(llc_valid), 32'd0);
    checkOutput("midrst.busy", 32'(busy), 32'd0);
    checkStats("midrst");
    step();
    rst_n = 1'b1;
    step();
    applyStimulus(0, 1'b1, 4'd1, 32'hC000);
    applyStimulus(1, 1'b1, 4'd2, 32'hC100);
    #1;
    checkOutput("postrst.ready", 32'({s_ready, i_ready, d_ready}), 32'b001);
    step();
    applyStimulus(0, 1'b0, 4'd0, 32'd0);
    checkOutput("postrst.cmd", 32'(llc_cmd), 32'd1);
    step();
    llc_ack = 1'b1;
    llc_hit = 1'b1;
    step();
    llc_ack = 1'b0;
    llc_hit = 1'b0;
    modelAck(4'd1, 1'b1);
    #1;
    checkOutput("postrst.ready_i", 32'({s_ready, i_ready, d_ready}), 32'b010);
    step();
    applyStimulus(1, 1'b0, 4'd0, 32'd0);
    checkOutput("postrst.cmd_i", 32'(llc_cmd), 32'd2);
    step();
    llc_ack = 1'b1;
    step();
    llc_ack = 1'b0;
    modelAck(4'd2, 1'b0);
    checkStats("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
